// File: rtl/cistercian_scan_driver_pkg.sv
// Shared types and constants for the Cistercian numeral scan driver:
// FSM states, BCD digit layout and the nibble correction used by double dabble.
package cistercian_scan_driver_pkg;

  localparam int MAX_VALUE  = 9999;
  localparam int CONV_STEPS = 14;
  localparam int BIN_W      = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  // A nibble of 5 or more would exceed 9 after doubling, so pre-correct it.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [BIN_W-1:0] saturate(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : v;
  endfunction

endpackage

// File: rtl/cistercian_scan_driver_if.sv
// Load/status handshake between a value source and the scan driver.
interface cistercian_scan_driver_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic        ovf;

  modport master (output value, load, input  busy, ovf);
  modport slave  (input  value, load, output busy, ovf);
endinterface

// File: rtl/cistercian_scan_driver_b2b.sv
// Sequential binary-to-BCD converter: one add-3/shift step per clock,
// started by a one-cycle pulse and finishing after CONV_STEPS steps.
module bin2bcd_seq
  import cistercian_scan_driver_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             last_o,
  output bcd_t             bcd_o
);

  logic [BIN_W-1:0] shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       step_q, step_d;
  logic             active_q, active_d;
  logic [15:0]      adj;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    step_d   = step_q;
    active_d = active_q;
    for (int i = 0; i < 4; i++) adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    if (start_i) begin
      shift_d  = bin_i;
      bcd_d    = '0;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d   = {adj[14:0], shift_q[BIN_W-1]};
      shift_d = {shift_q[BIN_W-2:0], 1'b0};
      step_d  = step_q + 4'd1;
      if (step_q == 4'(CONV_STEPS - 1)) active_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

  assign last_o = active_q && (step_q == 4'(CONV_STEPS - 1));
  assign bcd_o  = bcd_t'(bcd_q);

endmodule

// File: rtl/cistercian_scan_driver.sv
// Converts a loaded binary value to BCD and multiplexes the four digits onto
// a dual Cistercian decoder in two alternating glyph-half phases.
module cistercian_scan_driver
  import cistercian_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter int GUARD    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  cistercian_scan_driver_if.slave   bus,
  input  logic                      lamp_test,
  output logic [3:0]                dig1,
  output logic [3:0]                dig2,
  output logic                      phase,
  output logic                      lt_n,
  output logic                      bi
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e             state_q, state_d;
  logic               busy_q, busy_d, ovf_q, ovf_d, start_q, start_d;
  logic [BIN_W-1:0]   cap_q, cap_d;
  logic               cap_ovf_q, cap_ovf_d;
  bcd_t               pend_q, pend_d, disp_q, disp_d, conv_bcd;
  logic               pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d, bi_q, bi_d, lt_n_q, lt_n_d;
  logic [3:0]         dig1_q, dig1_d, dig2_q, dig2_d;
  logic               conv_start, conv_last, commit, accept, wrap;

  bin2bcd_seq u_b2b (
    .clk     (clk),
    .rst     (rst),
    .start_i (conv_start),
    .bin_i   (cap_q),
    .last_o  (conv_last),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    state_d    = state_q;
    conv_start = 1'b0;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE:   if (start_q) begin conv_start = 1'b1; state_d = ST_CONV; end
      ST_CONV:   if (conv_last) state_d = ST_COMMIT;
      ST_COMMIT: begin commit = 1'b1; state_d = ST_IDLE; end
      default:   state_d = ST_IDLE;
    endcase
  end

  // The result is staged in pend_q and only moves to disp_q when a new glyph starts.
  always_comb begin
    accept     = bus.load && !busy_q && (state_q == ST_IDLE);
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    start_d    = accept;
    cap_d      = cap_q;
    cap_ovf_d  = cap_ovf_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    wrap       = (cnt_q == CNT_W'(SCAN_DIV - 1));
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    phase_d    = wrap ? ~phase_q : phase_q;
    if (accept) begin
      busy_d    = 1'b1;
      cap_d     = saturate(bus.value);
      cap_ovf_d = (bus.value > BIN_W'(MAX_VALUE));
    end
    if (wrap && phase_q && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (commit) begin
      busy_d     = 1'b0;
      ovf_d      = cap_ovf_q;
      pend_d     = conv_bcd;
      pend_vld_d = 1'b1;
    end
    dig1_d = phase_d ? disp_d.hundreds  : disp_d.units;
    dig2_d = phase_d ? disp_d.thousands : disp_d.tens;
    bi_d   = (cnt_d >= CNT_W'(GUARD));
    lt_n_d = ~lamp_test;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      start_q    <= 1'b0;
      cap_q      <= '0;
      cap_ovf_q  <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      dig1_q     <= '0;
      dig2_q     <= '0;
      bi_q       <= 1'b0;
      lt_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      start_q    <= start_d;
      cap_q      <= cap_d;
      cap_ovf_q  <= cap_ovf_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      dig1_q     <= dig1_d;
      dig2_q     <= dig2_d;
      bi_q       <= bi_d;
      lt_n_q     <= lt_n_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;
  assign dig1     = dig1_q;
  assign dig2     = dig2_q;
  assign phase    = phase_q;
  assign bi       = bi_q;
  assign lt_n     = lt_n_q;

endmodule

// File: tb/tb_cistercian_scan_driver.sv
// Bench for cistercian_scan_driver: a cycle-count reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cistercian_scan_driver;

  localparam int SCAN_DIV = 16;
  localparam int GUARD    = 4;
  localparam int LAT      = 16;
  localparam int FRAME    = 2 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst, lamp_test;
  logic [3:0] dig1, dig2;
  logic       phase, lt_n, bi;
  int         checks = 0;
  int         errors = 0;

  cistercian_scan_driver_if bus_if();

  cistercian_scan_driver #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .lamp_test (lamp_test),
    .dig1      (dig1),
    .dig2      (dig2),
    .phase     (phase),
    .lt_n      (lt_n),
    .bi        (bi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: n counts edges since reset; a load accepted at edge n0
  // commits at n0+LAT and reaches the display at the next multiple of FRAME.
  bit model_on = 0;
  int n = 0, n0 = 0, acc_value = 0, pend_val = 0, disp_val = 0;
  bit in_flight = 0, pend_valid = 0, ovf_m = 0, lt_n_m = 1;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      model_on = 1; n = 0; in_flight = 0; pend_valid = 0;
      disp_val = 0; ovf_m = 0; lt_n_m = 1;
    end else if (model_on) begin
      n++;
      lt_n_m = !lamp_test;
      if (n % FRAME == 0 && pend_valid) begin
        disp_val = pend_val;
        pend_valid = 0;
      end
      if (in_flight && n == n0 + LAT) begin
        in_flight = 0;
        pend_val = (acc_value > 9999) ? 9999 : acc_value;
        pend_valid = 1;
        ovf_m = (acc_value > 9999);
      end else if (!in_flight && bus_if.load) begin
        in_flight = 1;
        n0 = n;
        acc_value = int'(bus_if.value);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      int ph, cnt;
      ph  = (n / SCAN_DIV) % 2;
      cnt = n % SCAN_DIV;
      check("busy",  32'(bus_if.busy), 32'(in_flight));
      check("ovf",   32'(bus_if.ovf),  32'(ovf_m));
      check("phase", 32'(phase), 32'(ph));
      check("bi",    32'(bi),    32'(cnt >= GUARD));
      check("lt_n",  32'(lt_n),  32'(lt_n_m));
      check("dig1",  32'(dig1),  32'(ph ? (disp_val / 100) % 10  : disp_val % 10));
      check("dig2",  32'(dig2),  32'(ph ? (disp_val / 1000) % 10 : (disp_val / 10) % 10));
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    bus_if.value = 14'(v);
    bus_if.load  = 1'b1;
    tick();
    bus_if.load  = 1'b0;
  endtask

  task automatic measure_busy(output int c);
    c = 0;
    while (bus_if.busy === 1'b1 && c < 64) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_p0_boundary();
    bit   found = 0;
    logic prev;
    for (int c = 0; c < 100 && !found; c++) begin
      prev = phase;
      tick();
      if (prev === 1'b1 && phase === 1'b0) found = 1;
    end
    check("p0_boundary_seen", 32'(found), 32'd1);
  endtask

  task automatic check_glyph(input string tag, input int u, input int t, input int h, input int th);
    check({tag, "_ph0"},  32'(phase), 32'd0);
    check({tag, "_units"}, 32'(dig1), 32'(u));
    check({tag, "_tens"},  32'(dig2), 32'(t));
    tick(SCAN_DIV);
    check({tag, "_ph1"},  32'(phase), 32'd1);
    check({tag, "_hund"},  32'(dig1), 32'(h));
    check({tag, "_thou"},  32'(dig2), 32'(th));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, "_ovf"},  32'(bus_if.ovf),  32'd0);
    check({tag, "_dig1"}, 32'(dig1),  32'd0);
    check({tag, "_dig2"}, 32'(dig2),  32'd0);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_bi"},   32'(bi),    32'd0);
    check({tag, "_lt_n"}, 32'(lt_n),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; lamp_test = 1'b0; bus_if.load = 1'b0; bus_if.value = '0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    do_load(1234);
    measure_busy(c);
    check("busy_len_1234", 32'(c), 32'd16);
    wait_p0_boundary();
    check_glyph("v1234", 4, 3, 2, 1);

    do_load(12000);
    measure_busy(c);
    check("ovf_set", 32'(bus_if.ovf), 32'd1);
    wait_p0_boundary();
    check_glyph("v9999", 9, 9, 9, 9);
    do_load(5);
    measure_busy(c);
    check("ovf_clear", 32'(bus_if.ovf), 32'd0);
    wait_p0_boundary();
    check_glyph("v5", 5, 0, 0, 0);

    do_load(7);
    tick(4);
    do_load(42);
    measure_busy(c);
    check("busy_len_7", 32'(c + 5), 32'd16);
    wait_p0_boundary();
    check_glyph("v7", 7, 0, 0, 0);

    wait_p0_boundary();
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      check("scan_phase", 32'(phase), 32'((i / SCAN_DIV) % 2));
      check("scan_bi",    32'(bi),    32'((i % SCAN_DIV) >= GUARD));
      tick();
    end

    do_load(4321);
    tick(3);
    lamp_test = 1'b1;
    tick();
    check("lamp_lt_n", 32'(lt_n), 32'd0);
    measure_busy(c);
    check("busy_len_lamp", 32'(c + 4), 32'd16);
    lamp_test = 1'b0;
    wait_p0_boundary();
    check_glyph("v4321", 1, 2, 3, 4);

    do_load(8765);
    tick(7);
    rst = 1'b1;
    bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
    check_reset_outputs("abort");
    rst = 1'b0;
    wait_p0_boundary();
    check_glyph("after_abort", 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus_if.load  = ($urandom_range(0, 9) == 0);
      bus_if.value = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(10000, 16383))
                                                 : 14'($urandom_range(0, 9999));
      if ($urandom_range(0, 15) == 0) lamp_test = ~lamp_test;
      tick();
    end
    rst = 1'b0; bus_if.load = 1'b0; lamp_test = 1'b0;
    tick(3 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
